// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions: default Q-format widths, multiplier FSM
// states and the radix-4 Booth digit decoder.
package fixed_pkg;

  localparam int N_DEFAULT     = 16;
  localparam int FRAC_DEFAULT  = 10;
  localparam int OUT_W_DEFAULT = 16;
  localparam int PROD_W_DEFAULT = 2 * N_DEFAULT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Select code for one radix-4 Booth digit: value = zero ? 0 : (neg ? -1 : 1) * (two ? 2M : M)
  typedef struct packed {
    logic zero;
    logic neg;
    logic two;
  } booth_sel_t;

  // Decode multiplier bits {2i+1, 2i, 2i-1} into a Booth digit in {0, +-M, +-2M}.
  function automatic booth_sel_t booth_decode(input logic [2:0] bits);
    booth_sel_t sel;
    sel.zero = (bits == 3'b000) || (bits == 3'b111);
    sel.two  = (bits == 3'b011) || (bits == 3'b100);
    sel.neg  = bits[2] && !sel.zero;
    return sel;
  endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational Q-format rescale: optional round-half-up, arithmetic shift
// right by FRAC, then saturation to a signed OUT_W result with overflow flag.
module fixed_round_sat
  import fixed_pkg::*;
#(
  parameter int IN_W  = PROD_W_DEFAULT,
  parameter int FRAC  = FRAC_DEFAULT,
  parameter int OUT_W = OUT_W_DEFAULT
) (
  input  logic [IN_W-1:0]  product,
  input  logic             round_en,
  output logic [OUT_W-1:0] result,
  output logic             ovf
);

  // Width of the value left after dropping the fraction bits.
  localparam int SW = IN_W + 1 - FRAC;

  logic [IN_W:0]   ext;
  logic [IN_W:0]   half;
  logic [IN_W:0]   rounded;
  logic [SW-1:0]   scaled;
  logic [FRAC-1:0] unused_frac;

  // One extra bit of headroom so adding the rounding constant can never wrap.
  always_comb begin
    ext           = {product[IN_W-1], product};
    half          = '0;
    half[FRAC-1]  = round_en;
    rounded       = ext + half;
    scaled        = rounded[IN_W:FRAC];
  end

  assign unused_frac = rounded[FRAC-1:0];

  if (SW > OUT_W) begin : g_sat
    logic [SW-OUT_W:0] top;

    // Clamp when the bits above the result sign are not a pure sign extension.
    always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
      result = scaled[OUT_W-1:0];
      top    = scaled[SW-1:OUT_W-1];
      ovf    = !((&top) || !(|top));
      if (ovf) begin
        result = scaled[SW-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                              : {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end else begin : g_ext
    // Result is wide enough to hold every scaled value: sign-extend only.
    always_comb begin
      result          = {OUT_W{scaled[SW-1]}};
      result[SW-1:0]  = scaled;
      ovf             = 1'b0;
    end
  end

endmodule

// File: rtl/booth4_fixed_mul.sv
// Sequential radix-4 Booth multiplier for signed Q-format operands with
// valid/ready handshakes, rounding and saturating rescale of the product.
module booth4_fixed_mul
  import fixed_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int FRAC  = FRAC_DEFAULT,
  parameter int OUT_W = OUT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     m,
  input  logic [N-1:0]     r,
  input  logic             round_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             ovf
);

  localparam int MW    = N + 2;          // sign-extended multiplicand, holds +-2M
  localparam int AW    = 2 * N + 2;      // accumulator width
  localparam int STEPS = N / 2;          // radix-4 digits per product
  localparam int CW    = $clog2(STEPS + 1);

  state_t state, state_nxt;

  logic [MW-1:0]    m_q;
  logic [N:0]       r_q;                 // multiplier with appended 0 LSB
  logic             rnd_q;
  logic [AW-1:0]    acc_q;
  logic [CW-1:0]    count_q;

  booth_sel_t       sel;
  logic [MW-1:0]    pp;
  logic [AW:0]      acc_sum;
  logic [AW:0]      acc_shift;

  logic [OUT_W-1:0] rs_result;
  logic             rs_ovf;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
    end
  end

  // Next-state logic: accept in IDLE, N/2 Booth steps, one rescale cycle, hold until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)                     state_nxt = RUN;
      RUN:  if (count_q == CW'(STEPS - 1))    state_nxt = FIN;
      FIN:                                    state_nxt = DONE;
      DONE: if (out_ready)                    state_nxt = IDLE;
      default:                                state_nxt = IDLE;
    endcase
  end

  // One Booth step: pick the digit, add it at the top of the accumulator, shift right by two.
  always_comb begin
    sel = booth_decode(r_q[2:0]);
    pp  = '0;
    if (!sel.zero) begin
      pp = sel.two ? {m_q[MW-2:0], 1'b0} : m_q;
    end
    if (sel.neg) begin
      pp = -pp;
    end
    acc_sum   = {acc_q[AW-1], acc_q} + {pp[MW-1], pp, {N{1'b0}}};
    acc_shift = {{2{acc_sum[AW]}}, acc_sum[AW:2]};
  end

  // Datapath registers: operand capture, Booth iteration, result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q     <= '0;
      r_q     <= '0;
      rnd_q   <= 1'b0;
      acc_q   <= '0;
      count_q <= '0;
      result  <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m_q     <= {{2{m[N-1]}}, m};
            r_q     <= {r, 1'b0};
            rnd_q   <= round_en;
            acc_q   <= '0;
            count_q <= '0;
          end
        end
        RUN: begin
          acc_q   <= acc_shift[AW-1:0];
          r_q     <= {{2{r_q[N]}}, r_q[N:2]};
          count_q <= count_q + CW'(1);
        end
        FIN: begin
          result <= rs_result;
          ovf    <= rs_ovf;
        end
        default: ;
      endcase
    end
  end

  fixed_round_sat #(
    .IN_W  (2 * N),
    .FRAC  (FRAC),
    .OUT_W (OUT_W)
  ) u_round_sat (
    .product  (acc_q[2*N-1:0]),
    .round_en (rnd_q),
    .result   (rs_result),
    .ovf      (rs_ovf)
  );

endmodule

// File: tb/tb_booth4_fixed_mul.sv
// Self-checking bench for booth4_fixed_mul (N=16, FRAC=10, OUT_W=16):
// directed vectors with literal expectations plus a scoreboard fed by an
// arithmetic reference model sat(round(m*r) >>> FRAC).
module tb_booth4_fixed_mul;

  localparam int N     = 16;
  localparam int FRAC  = 10;
  localparam int OUT_W = 16;
  localparam int LAT   = N / 2 + 2;   // edges from accept (inclusive) to out_valid

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     m_i;
  logic [N-1:0]     r_i;
  logic             round_i;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] result;
  logic             ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [OUT_W:0] exp_q[$];           // {ovf, result} per accepted operation

  booth4_fixed_mul #(.N(N), .FRAC(FRAC), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .m         (m_i),
    .r         (r_i),
    .round_en  (round_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact product, optional +2^(FRAC-1), arithmetic shift, clamp.
  function automatic logic [OUT_W:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic rnd);
    longint p;
    p = longint'(signed'(a)) * longint'(signed'(b));
    if (rnd) p += longint'(1) << (FRAC - 1);
    p = p >>> FRAC;
    if (p > 32767)  return {1'b1, 16'h7FFF};
    if (p < -32768) return {1'b1, 16'h8000};
    return {1'b0, p[15:0]};
  endfunction

  // Scoreboard: record accepted operands, compare every cycle a result is presented.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          check("scoreboard {ovf,result}", {15'b0, ovf, result}, {15'b0, exp_q[0]});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(m_i, r_i, round_i));
    end
  end

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!in_ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) check({name, " ready timeout"}, {31'b0, in_ready}, 32'd1);
  endtask

  // Single operation with out_ready high: checks latency and literal result.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic rnd,
                       input logic [OUT_W-1:0] exp_res, input logic exp_ovf, input string name);
    int cnt;
    out_ready = 1'b1;
    wait_ready(name);
    m_i = a; r_i = b; round_i = rnd; in_valid = 1'b1;
    @(posedge clk); #1;               // accept edge
    in_valid = 1'b0;
    m_i = '0; r_i = '0; round_i = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({name, " latency"}, cnt, LAT);
    check({name, " result"}, {16'b0, result}, {16'b0, exp_res});
    check({name, " ovf"}, {31'b0, ovf}, {31'b0, exp_ovf});
    @(posedge clk); #1;               // output handshake
  endtask

  initial begin
    int k;
    logic [N-1:0] specials [4];
    specials[0] = 16'h8000; specials[1] = 16'h7FFF;
    specials[2] = 16'h0000; specials[3] = 16'hFFFF;

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    m_i = '0; r_i = '0; round_i = 1'b0;
    #2;
    check("reset in_ready",  {31'b0, in_ready},  32'd1);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset result",    {16'b0, result},    32'd0);
    check("reset ovf",       {31'b0, ovf},       32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Pin the reference model with hand-computed values.
    check("model 1.5x2",     {15'b0, model(16'h0600, 16'h0800, 1'b0)}, {15'b0, 1'b0, 16'h0C00});
    check("model 8000x8000", {15'b0, model(16'h8000, 16'h8000, 1'b0)}, {15'b0, 1'b1, 16'h7FFF});
    check("model -1 rnd",    {15'b0, model(16'hFFFF, 16'h0200, 1'b1)}, {15'b0, 1'b0, 16'h0000});

    @(posedge clk); #1;
    do_op(16'h0600, 16'h0800, 1'b0, 16'h0C00, 1'b0, "1.5x2.0");
    do_op(16'hFA00, 16'h0800, 1'b0, 16'hF400, 1'b0, "-1.5x2.0");
    do_op(16'h0800, 16'hFA00, 1'b0, 16'hF400, 1'b0, "2.0x-1.5");
    do_op(16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 1'b1, "max x max");
    do_op(16'h8000, 16'h8000, 1'b0, 16'h7FFF, 1'b1, "min x min");
    do_op(16'h7FFF, 16'h8000, 1'b0, 16'h8000, 1'b1, "max x min");
    do_op(16'h0001, 16'h0200, 1'b0, 16'h0000, 1'b0, "lsb trunc");
    do_op(16'h0001, 16'h0200, 1'b1, 16'h0001, 1'b0, "lsb round");
    do_op(16'hFFFF, 16'h0200, 1'b1, 16'h0000, 1'b0, "neg half-up");
    do_op(16'h0000, 16'h8000, 1'b1, 16'h0000, 1'b0, "zero operand");

    // Back-pressure: hold the result in DONE while a new pair waits on in_valid.
    wait_ready("bp");
    m_i = 16'h7FFF; r_i = 16'h8000; round_i = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    m_i = 16'h0600; r_i = 16'h0800;
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp out_valid", {31'b0, out_valid}, 32'd1);
    repeat (5) begin
      check("bp result held",   {16'b0, result},   32'h8000);
      check("bp ovf held",      {31'b0, ovf},      32'd1);
      check("bp in_ready low",  {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;               // handshake edge
    check("bp idle out_valid", {31'b0, out_valid}, 32'd0);
    check("bp idle in_ready",  {31'b0, in_ready},  32'd1);
    @(posedge clk); #1;               // held pair accepted here
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp second latency", k, LAT);
    check("bp second result",  {16'b0, result}, 32'h0C00);
    @(posedge clk); #1;

    // Reset during RUN aborts the operation.
    wait_ready("rst");
    m_i = 16'h7FFF; r_i = 16'h7FFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort out_valid", {31'b0, out_valid}, 32'd0);
    check("abort in_ready",  {31'b0, in_ready},  32'd1);
    check("abort result",    {16'b0, result},    32'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (12) begin
      check("no stale out_valid", {31'b0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    do_op(16'h0600, 16'h0800, 1'b0, 16'h0C00, 1'b0, "after reset");

    // Random sweep with random output stalls; the scoreboard checks every result.
    for (int i = 0; i < 300; i++) begin
      m_i = (i % 8 == 0) ? specials[$urandom_range(0, 3)] : N'($urandom);
      r_i = (i % 8 == 4) ? specials[$urandom_range(0, 3)] : N'($urandom);
      round_i = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 100) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        k++;
      end
      if (!in_ready) check("sweep accept timeout", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("sweep drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
